// File: rtl/apb_bridge_n.sv
// apb_bridge_n: APB master bridge. Takes single read/write requests on a
// valid/ready port and runs each one as an APB SETUP/ACCESS transfer to one of
// NSLV slaves, selected by the top SLV_BITS address bits. Supports PREADY wait
// states, an optional stall timeout, per-slave PSLVERR and decode errors.
//
// Handshake: a request is taken at a rising PCLK edge where req_valid and
// req_ready are both high; req_ready is high only while the bridge is idle and
// out of reset. rsp_valid is a one-cycle pulse, and rsp_rdata/rsp_err hold
// their values until the next response.
module apb_bridge_n #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 9,
    parameter int NSLV     = 2,
    parameter int SLV_BITS = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [NSLV*DATA_W-1:0]   PRDATA,
    input  logic [NSLV-1:0]          PREADY,
    input  logic [NSLV-1:0]          PSLVERR
);

    // The wait counter only has to reach TIMEOUT; keep one bit when disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DERR   = 2'd3
    } state_t;

    state_t              state_q;
    logic [SLV_BITS-1:0] idx_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [NSLV-1:0]     psel_q;
    logic                penable_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [CNT_W-1:0]    wait_q;
    logic [CNT_W-1:0]    wait_d;

    logic [SLV_BITS-1:0] req_idx;
    logic                req_in_range;
    logic [NSLV-1:0]     req_sel;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    assign req_idx      = req_addr[ADDR_W-1 -: SLV_BITS];
    assign req_in_range = (32'(req_idx) < 32'(NSLV));
    assign wait_d       = wait_q + CNT_W'(1);
    assign timeout_hit  = (TIMEOUT > 0) && (wait_q == TO_LAST);

    // One-hot select for the incoming request's slave index.
    always_comb begin
        req_sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (req_idx == SLV_BITS'(k)) begin
                req_sel[k] = 1'b1;
            end
        end
    end

    // Pick out the active slave's PREADY/PSLVERR/PRDATA; others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == SLV_BITS'(k)) begin
                sel_ready = PREADY[k];
                sel_err   = PSLVERR[k];
                sel_rdata = PRDATA[k*DATA_W +: DATA_W];
            end
        end
    end

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        paddr_q  <= req_addr;
                        pwrite_q <= req_write;
                        pwdata_q <= req_wdata;
                        idx_q    <= req_idx;
                        wait_q   <= '0;
                        if (req_in_range) begin
                            psel_q  <= req_sel;
                            state_q <= S_SETUP;
                        end else begin
                            // Unmapped slave index: never touch the bus.
                            state_q <= S_DERR;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= sel_err;
                        // A read that errors still returns what the slave drove.
                        rsp_rdata_q <= pwrite_q ? '0 : sel_rdata;
                        state_q     <= S_IDLE;
                    end else if (timeout_hit) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_DERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) && !PRESET;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_n.sv
// tb_apb_bridge_n: directed bench for apb_bridge_n. Instance 0 uses the default
// two-slave configuration; instance 1 has three slaves on two index bits so an
// unmapped index exists. A transaction-level model turns each request into the
// cycles where PSEL/PENABLE/busy/response must appear; one compare process
// checks both instances against it every cycle.
`timescale 1ns/1ps
module tb_apb_bridge_n;

    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- instance 0: 2 slaves ----------------
    logic        req_valid0, req_ready0, req_write0;
    logic [8:0]  req_addr0;
    logic [7:0]  req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [7:0]  rsp_rdata0;
    logic [8:0]  PADDR0;
    logic [1:0]  PSEL0;
    logic        PENABLE0, PWRITE0;
    logic [7:0]  PWDATA0;
    logic [15:0] PRDATA0;
    logic [1:0]  PREADY0, PSLVERR0;

    apb_bridge_n #(.DATA_W(8), .ADDR_W(9), .NSLV(2), .SLV_BITS(1), .TIMEOUT(TO)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .PADDR(PADDR0), .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0),
        .PWDATA(PWDATA0), .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0)
    );

    // ---------------- instance 1: 3 slaves, 2 index bits ----------------
    logic        req_valid1, req_ready1, req_write1;
    logic [8:0]  req_addr1;
    logic [7:0]  req_wdata1;
    logic        rsp_valid1, rsp_err1;
    logic [7:0]  rsp_rdata1;
    logic [8:0]  PADDR1;
    logic [2:0]  PSEL1;
    logic        PENABLE1, PWRITE1;
    logic [7:0]  PWDATA1;
    logic [23:0] PRDATA1;
    logic [2:0]  PREADY1, PSLVERR1;

    apb_bridge_n #(.DATA_W(8), .ADDR_W(9), .NSLV(3), .SLV_BITS(2), .TIMEOUT(TO)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .PADDR(PADDR1), .PSEL(PSEL1), .PENABLE(PENABLE1), .PWRITE(PWRITE1),
        .PWDATA(PWDATA1), .PRDATA(PRDATA1), .PREADY(PREADY1), .PSLVERR(PSLVERR1)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model keyed by 2*cycle + instance; an entry's presence means "expected here".
    logic [2:0] m_psel   [int];
    bit         m_pen    [int];
    bit         m_busy   [int];
    logic [8:0] m_paddr  [int];
    logic       m_pwrite [int];
    logic [7:0] m_pwdata [int];
    logic [7:0] m_rdata  [int];
    logic       m_err    [int];

    // Held expectations (bus fields and last response), per instance.
    logic [8:0] h_paddr  [2];
    logic       h_pwrite [2];
    logic [7:0] h_pwdata [2];
    logic [7:0] h_rdata  [2];
    logic       h_err    [2];

    // Observation counters for the literal checks.
    int pen_cnt  [2];
    int psel_cnt [2];
    int rv_cyc   [2];

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge PCLK) begin : cmp
        int k;
        logic [2:0] a_psel;
        logic a_pen, a_rdy, a_rv, a_err, a_pwrite;
        logic [7:0] a_rd, a_pwdata;
        logic [8:0] a_paddr;
        for (int i = 0; i < 2; i++) begin
            k        = 2 * cyc + i;
            a_psel   = (i == 0) ? {1'b0, PSEL0} : PSEL1;
            a_pen    = (i == 0) ? PENABLE0   : PENABLE1;
            a_rdy    = (i == 0) ? req_ready0 : req_ready1;
            a_rv     = (i == 0) ? rsp_valid0 : rsp_valid1;
            a_err    = (i == 0) ? rsp_err0   : rsp_err1;
            a_rd     = (i == 0) ? rsp_rdata0 : rsp_rdata1;
            a_paddr  = (i == 0) ? PADDR0     : PADDR1;
            a_pwrite = (i == 0) ? PWRITE0    : PWRITE1;
            a_pwdata = (i == 0) ? PWDATA0    : PWDATA1;
            if (a_pen) pen_cnt[i]++;
            if (a_psel != 3'b000) psel_cnt[i]++;
            if (a_rv) rv_cyc[i] = cyc;
            if (PRESET) begin
                h_paddr[i] = '0; h_pwrite[i] = 1'b0; h_pwdata[i] = '0;
                h_rdata[i] = '0; h_err[i] = 1'b0;
            end
            if (chk_en) begin
                if (m_paddr.exists(k)) begin
                    h_paddr[i] = m_paddr[k]; h_pwrite[i] = m_pwrite[k]; h_pwdata[i] = m_pwdata[k];
                end
                if (m_err.exists(k)) begin
                    h_rdata[i] = m_rdata[k]; h_err[i] = m_err[k];
                end
                chk("psel", i, 32'(a_psel), m_psel.exists(k) ? 32'(m_psel[k]) : 32'd0);
                chk("penable", i, 32'(a_pen), 32'(m_pen.exists(k)));
                chk("req_ready", i, 32'(a_rdy), 32'(!m_busy.exists(k)));
                chk("paddr", i, 32'(a_paddr), 32'(h_paddr[i]));
                chk("pwrite", i, 32'(a_pwrite), 32'(h_pwrite[i]));
                chk("pwdata", i, 32'(a_pwdata), 32'(h_pwdata[i]));
                chk("rsp_valid", i, 32'(a_rv), 32'(m_err.exists(k)));
                chk("rsp_rdata", i, 32'(a_rd), 32'(h_rdata[i]));
                chk("rsp_err", i, 32'(a_err), 32'(h_err[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int inst, input logic v, input logic w,
                           input logic [8:0] a, input logic [7:0] d);
        if (inst == 0) begin
            req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = d;
        end else begin
            req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = d;
        end
    endtask

    // Randomise every slave of an instance, then force the chosen one.
    task automatic set_slv(input int inst, input int idx, input logic rdy,
                           input logic [7:0] rd, input logic err);
        if (inst == 0) begin
            PREADY0 = 2'($urandom); PSLVERR0 = 2'($urandom); PRDATA0 = 16'($urandom);
            if (idx >= 0 && idx < 2) begin
                PREADY0[idx] = rdy; PSLVERR0[idx] = err; PRDATA0[idx*8 +: 8] = rd;
            end
        end else begin
            PREADY1 = 3'($urandom); PSLVERR1 = 3'($urandom); PRDATA1 = 24'($urandom);
            if (idx >= 0 && idx < 3) begin
                PREADY1[idx] = rdy; PSLVERR1[idx] = err; PRDATA1[idx*8 +: 8] = rd;
            end
        end
    endtask

    // One request: 'waits' PREADY-low ACCESS cycles before completion (beyond
    // TO means the slave never answers). Call and return inside a cycle, #1
    // after its rising edge; returns in the response cycle.
    task automatic xfer(input int inst, input logic wr, input logic [8:0] addr,
                        input logic [7:0] wd, input int waits,
                        input logic [7:0] rd, input logic err);
        int c, idx, nslv, eff, last, rc;
        bit to, dec;
        c    = cyc;
        nslv = (inst == 0) ? 2 : 3;
        idx  = (inst == 0) ? int'(addr[8]) : int'(addr[8:7]);
        dec  = (idx >= nslv);
        to   = !dec && (waits > TO);
        eff  = to ? TO : waits;
        last = c + 2 + eff;
        rc   = dec ? c + 2 : last + 1;
        m_paddr[2*(c+1)+inst]  = addr;
        m_pwrite[2*(c+1)+inst] = wr;
        m_pwdata[2*(c+1)+inst] = wd;
        for (int n = c + 1; n < rc; n++) begin
            m_busy[2*n+inst] = 1'b1;
            if (!dec) begin
                m_psel[2*n+inst] = 3'(1 << idx);
                if (n >= c + 2) m_pen[2*n+inst] = 1'b1;
            end
        end
        m_rdata[2*rc+inst] = (dec || to || wr) ? 8'h00 : rd;
        m_err[2*rc+inst]   = dec || to || err;

        set_req(inst, 1'b1, wr, addr, wd);
        @(posedge PCLK); #1;
        while (cyc < rc) begin
            set_req(inst, 1'($urandom), 1'($urandom), 9'($urandom), 8'($urandom));
            if (!dec && !to && cyc == last)
                set_slv(inst, idx, 1'b1, rd, err);
            else
                set_slv(inst, idx, (cyc == c + 1) ? 1'($urandom) : 1'b0,
                        8'($urandom), 1'($urandom));
            @(posedge PCLK); #1;
        end
        set_req(inst, 1'b0, 1'($urandom), 9'($urandom), 8'($urandom));
        set_slv(inst, -1, 1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s, p, q;
        PRESET = 1'b1;
        set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
        set_req(1, 1'b0, 1'b0, 9'h000, 8'h00);
        PREADY0 = '0; PSLVERR0 = '0; PRDATA0 = '0;
        PREADY1 = '0; PSLVERR1 = '0; PRDATA1 = '0;
        repeat (3) @(posedge PCLK);
        #1;
        // Reset values.
        chk("rst_psel", 0, 32'(PSEL0), 0);
        chk("rst_penable", 0, 32'(PENABLE0), 0);
        chk("rst_paddr", 0, 32'(PADDR0), 0);
        chk("rst_pwrite", 0, 32'(PWRITE0), 0);
        chk("rst_pwdata", 0, 32'(PWDATA0), 0);
        chk("rst_rsp_valid", 0, 32'(rsp_valid0), 0);
        chk("rst_rsp_rdata", 0, 32'(rsp_rdata0), 0);
        chk("rst_rsp_err", 0, 32'(rsp_err0), 0);
        chk("rst_req_ready", 0, 32'(req_ready0), 0);
        chk("rst_psel1", 1, 32'(PSEL1), 0);
        PRESET = 1'b0;
        chk_en = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write then back-to-back read, slave 1.
        s = cyc; p = pen_cnt[0]; q = psel_cnt[0];
        xfer(0, 1'b1, 9'h105, 8'hA5, 0, 8'h00, 1'b0);
        @(negedge PCLK); #1;
        chk("wr_latency", 0, 32'(rv_cyc[0] - s), 3);
        chk("wr_pen_cycles", 0, 32'(pen_cnt[0] - p), 1);
        chk("wr_psel_cycles", 0, 32'(psel_cnt[0] - q), 2);
        chk("wr_rsp_err", 0, 32'(rsp_err0), 0);
        s = cyc; p = pen_cnt[0];
        xfer(0, 1'b0, 9'h105, 8'h3E, 0, 8'hA5, 1'b0);
        @(negedge PCLK); #1;
        chk("rd_latency", 0, 32'(rv_cyc[0] - s), 3);
        chk("rd_pen_cycles", 0, 32'(pen_cnt[0] - p), 1);
        chk("rd_rdata", 0, 32'(rsp_rdata0), 32'h00A5);
        chk("rd_rsp_err", 0, 32'(rsp_err0), 0);

        // Four wait states on a read of 0x003.
        @(posedge PCLK); #1;
        s = cyc; p = pen_cnt[0];
        xfer(0, 1'b0, 9'h003, 8'h00, 4, 8'h3C, 1'b0);
        @(negedge PCLK); #1;
        chk("wait_latency", 0, 32'(rv_cyc[0] - s), 7);
        chk("wait_pen_cycles", 0, 32'(pen_cnt[0] - p), 5);
        chk("wait_rdata", 0, 32'(rsp_rdata0), 32'h003C);
        chk("wait_paddr", 0, 32'(PADDR0), 32'h0003);

        // Slave never answers: timeout after 16 ACCESS cycles.
        s = cyc; p = pen_cnt[0];
        xfer(0, 1'b0, 9'h010, 8'h00, 100, 8'hFF, 1'b0);
        @(negedge PCLK); #1;
        chk("to_latency", 0, 32'(rv_cyc[0] - s), 18);
        chk("to_pen_cycles", 0, 32'(pen_cnt[0] - p), 16);
        chk("to_rsp_err", 0, 32'(rsp_err0), 1);
        chk("to_rdata", 0, 32'(rsp_rdata0), 0);

        // Slave error on a write, then a clean read; then an erroring read.
        xfer(0, 1'b1, 9'h1F0, 8'h77, 1, 8'h00, 1'b1);
        @(negedge PCLK); #1;
        chk("slverr_wr_err", 0, 32'(rsp_err0), 1);
        xfer(0, 1'b0, 9'h1F0, 8'h12, 0, 8'h99, 1'b0);
        @(negedge PCLK); #1;
        chk("after_err_err", 0, 32'(rsp_err0), 0);
        chk("after_err_rdata", 0, 32'(rsp_rdata0), 32'h0099);
        xfer(0, 1'b0, 9'h0AA, 8'h00, 2, 8'h5E, 1'b1);
        @(negedge PCLK); #1;
        chk("slverr_rd_err", 0, 32'(rsp_err0), 1);
        chk("slverr_rd_rdata", 0, 32'(rsp_rdata0), 32'h005E);

        // Decode error on the three-slave instance (index 3), then slave 2.
        @(posedge PCLK); #1;
        s = cyc; q = psel_cnt[1];
        xfer(1, 1'b1, 9'h1C0, 8'h44, 0, 8'h00, 1'b0);
        @(negedge PCLK); #1;
        chk("derr_latency", 1, 32'(rv_cyc[1] - s), 2);
        chk("derr_psel_cycles", 1, 32'(psel_cnt[1] - q), 0);
        chk("derr_rsp_err", 1, 32'(rsp_err1), 1);
        s = cyc; q = psel_cnt[1];
        xfer(1, 1'b0, 9'h105, 8'h00, 2, 8'h42, 1'b0);
        @(negedge PCLK); #1;
        chk("s2_latency", 1, 32'(rv_cyc[1] - s), 5);
        chk("s2_psel_cycles", 1, 32'(psel_cnt[1] - q), 4);
        chk("s2_rdata", 1, 32'(rsp_rdata1), 32'h0042);

        // Reset during a stalled ACCESS: select drops at once, no response.
        @(posedge PCLK); #1;
        chk_en = 1'b0;
        set_req(0, 1'b1, 1'b0, 9'h003, 8'h11);
        @(posedge PCLK); #1;
        set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
        set_slv(0, 0, 1'b0, 8'h00, 1'b0);
        repeat (2) begin
            @(posedge PCLK); #1;
            set_slv(0, 0, 1'b0, 8'h00, 1'b0);
        end
        chk("mid_psel_before", 0, 32'(PSEL0), 32'h1);
        chk("mid_pen_before", 0, 32'(PENABLE0), 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("mid_psel_async", 0, 32'(PSEL0), 0);
        chk("mid_pen_async", 0, 32'(PENABLE0), 0);
        chk("mid_req_ready", 0, 32'(req_ready0), 0);
        repeat (3) begin
            @(posedge PCLK); #1;
            chk("mid_no_rsp", 0, 32'(rsp_valid0), 0);
        end
        chk("mid_paddr", 0, 32'(PADDR0), 0);
        PRESET = 1'b0;
        chk_en = 1'b1;
        @(posedge PCLK); #1;
        s = cyc;
        xfer(0, 1'b0, 9'h120, 8'h00, 0, 8'h81, 1'b0);
        @(negedge PCLK); #1;
        chk("post_rst_latency", 0, 32'(rv_cyc[0] - s), 3);
        chk("post_rst_rdata", 0, 32'(rsp_rdata0), 32'h0081);
        chk("post_rst_err", 0, 32'(rsp_err0), 0);

        repeat (3) @(posedge PCLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
